// File: rtl/dff_pkg.sv
// Shared constants for the dff level/edge synchronizer.
package dff_pkg;

  localparam int DFF_MIN_STAGES     = 2;
  localparam int DFF_MAX_STAGES     = 8;
  localparam int DFF_DEFAULT_STAGES = 2;

  function automatic bit dff_stages_ok(input int stages);
    return (stages >= DFF_MIN_STAGES) && (stages <= DFF_MAX_STAGES);
  endfunction

endpackage

// File: rtl/dff_sync_stage.sv
// One resettable synchronizer flop, marked so placement keeps the chain tight.
module dff_sync_stage #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic q_r;

  always_ff @(posedge clk) begin
    if (resetb) q_r <= RESET_VAL;
    else        q_r <= d;
  end

  assign q = q_r;

endmodule

// File: rtl/dff.sv
// Multi-flop synchronizer for pulse_in into the clk domain.
// Define DFF_EDGE_DET_EN to turn pulse_out into a one-cycle rising-edge pulse.
module dff
  import dff_pkg::*;
#(
  parameter int   STAGES    = DFF_DEFAULT_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetb,
  input  logic pulse_in,
  output logic pulse_out,
  output logic sync_level
);

  if (!dff_stages_ok(STAGES)) begin : g_bad_stages
    $error("dff: STAGES=%0d outside %0d..%0d", STAGES, DFF_MIN_STAGES, DFF_MAX_STAGES);
  end

  logic [STAGES-1:0] sync;
  logic [STAGES-1:0] chain_d;

  // Stage i is fed by stage i-1; stage 0 takes the raw async input directly.
  assign chain_d = {sync[STAGES-2:0], pulse_in};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    dff_sync_stage #(.RESET_VAL(RESET_VAL)) u_stage (
      .clk    (clk),
      .resetb (resetb),
      .d      (chain_d[i]),
      .q      (sync[i])
    );
  end

  assign sync_level = sync[STAGES-1];

`ifdef DFF_EDGE_DET_EN
  logic sync_d;

  always_ff @(posedge clk) begin
    if (resetb) sync_d <= RESET_VAL;
    else        sync_d <= sync[STAGES-1];
  end

  assign pulse_out = sync[STAGES-1] & ~sync_d;
`else
  assign pulse_out = sync[STAGES-1];
`endif

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff at STAGES=2 and STAGES=4 side by side.
module tb_dff;

  logic clk = 1'b0;
  logic src_clk = 1'b0;
  logic resetb = 1'b1;
  logic pulse_in = 1'b0;
  logic po2, sl2, po4, sl4;
  int checks = 0;
  int failures = 0;

`ifdef DFF_EDGE_DET_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #10 src_clk = ~src_clk;
  end

  dff #(.STAGES(2), .RESET_VAL(1'b0)) dut2 (
    .clk(clk), .resetb(resetb), .pulse_in(pulse_in), .pulse_out(po2), .sync_level(sl2)
  );
  dff #(.STAGES(4), .RESET_VAL(1'b0)) dut4 (
    .clk(clk), .resetb(resetb), .pulse_in(pulse_in), .pulse_out(po4), .sync_level(sl4)
  );

  // Expected {pulse2, level2, pulse4, level4} after each edge; a delay queue
  // per depth, flushed to zeros whenever reset is sampled.
  logic m2[$];
  logic m4[$];
  logic [3:0] exp_q[$];
  logic mp2 = 1'b0;
  logic mp4 = 1'b0;

  always @(posedge clk) begin : sb_model
    logic l2, l4, p2, p4;
    if (resetb) begin
      m2 = '{1'b0};
      m4 = '{1'b0, 1'b0, 1'b0};
      l2 = 1'b0;
      l4 = 1'b0;
    end else begin
      m2.push_back(pulse_in);
      l2 = m2.pop_front();
      m4.push_back(pulse_in);
      l4 = m4.pop_front();
    end
    p2 = EDGE ? (l2 & ~mp2) : l2;
    p4 = EDGE ? (l4 & ~mp4) : l4;
    mp2 = l2;
    mp4 = l4;
    exp_q.push_back({p2, l2, p4, l4});
  end

  task automatic test_reset();
    logic [3:0] e, g;
    for (int i = 0; i < 5; i++) begin
      resetb = (i < 2);
      pulse_in = 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      g = {po2, sl2, po4, sl4};
      checks++;
      if (g !== 4'b0000 || g !== e) begin
        failures++;
        $display("FAIL reset cyc%0d got=%b exp=%b", i, g, e);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [3:0] e, g;
    int n2 = 0, n4 = 0, first = -1;
    fork
      begin
        @(posedge src_clk); pulse_in = 1'b1;
        @(negedge src_clk); pulse_in = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        g = {po2, sl2, po4, sl4};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL single_pulse cyc%0d got=%b exp=%b", i, g, e);
        end
        if (po2 === 1'b1) begin n2++; if (first < 0) first = i; end
        if (po4 === 1'b1) n4++;
      end
    join
    checks++;
    if (n2 != 1 || n4 != 1) begin
      failures++;
      $display("FAIL single_pulse_count got=%0d/%0d exp=1/1", n2, n4);
    end
  endtask

  task automatic test_long_level();
    logic [3:0] e, g;
    int np = 0, nl = 0, first = -1;
    for (int i = 0; i < 12; i++) begin
      pulse_in = (i < 5);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {po2, sl2, po4, sl4};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL long_level cyc%0d got=%b exp=%b", i, g, e);
      end
      if (po2 === 1'b1) np++;
      if (sl2 === 1'b1) begin nl++; if (first < 0) first = i; end
    end
    checks++;
    if (np != (EDGE ? 1 : 5) || nl != 5 || first != 1) begin
      failures++;
      $display("FAIL long_level_shape got=p%0d/l%0d/at%0d exp=p%0d/l5/at1", np, nl, first, EDGE ? 1 : 5);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] e, g;
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      pulse_in = (i == 0);
      resetb = (i == 1);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {po2, sl2, po4, sl4};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL mid_reset cyc%0d got=%b exp=%b", i, g, e);
      end
      if (po2 === 1'b1 || po4 === 1'b1 || sl2 === 1'b1 || sl4 === 1'b1) n++;
    end
    resetb = 1'b0;
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL mid_reset_leak got=%0d exp=0", n);
    end
  endtask

  task automatic test_stages4_level();
    logic [3:0] e, g;
    int n = 0, first = -1;
    for (int i = 0; i < 10; i++) begin
      pulse_in = (i < 3);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {po2, sl2, po4, sl4};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL stages4 cyc%0d got=%b exp=%b", i, g, e);
      end
      if (po4 === 1'b1) n++;
      if (sl4 === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (n != (EDGE ? 1 : 3) || first != 3) begin
      failures++;
      $display("FAIL stages4_shape got=n%0d/at%0d exp=n%0d/at3", n, first, EDGE ? 1 : 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e, g;
    int hits[$];
    for (int i = 0; i < 10; i++) begin
      pulse_in = (i == 0 || i == 3);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {po2, sl2, po4, sl4};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d got=%b exp=%b", i, g, e);
      end
      if (po2 === 1'b1) hits.push_back(i);
    end
    checks++;
    if (hits.size() != 2 || hits[1] - hits[0] != 3) begin
      failures++;
      $display("FAIL back_to_back_gap got=n%0d exp=2 pulses 3 apart", hits.size());
    end
  endtask

  task automatic test_release_high();
    logic [3:0] e, g;
    int n2 = 0, first = -1;
    for (int i = 0; i < 14; i++) begin
      resetb = (i < 2);
      pulse_in = (i < 9);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {po2, sl2, po4, sl4};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL release_high cyc%0d got=%b exp=%b", i, g, e);
      end
      if (po2 === 1'b1) begin n2++; if (first < 0) first = i; end
    end
    checks++;
    if ((EDGE && n2 != 1) || first != 3) begin
      failures++;
      $display("FAIL release_high_pulse got=n%0d/at%0d exp=at3", n2, first);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_pulse();
    test_long_level();
    test_mid_reset();
    test_stages4_level();
    test_back_to_back();
    test_release_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 The block SHALL have parameter STAGES, default 2, giving the synchronizer depth in flops (legal range 2..8).
REQ-002 The block SHALL have parameter RESET_VAL, default 1'b0, giving the reset value of every synchronizer flop.
REQ-003 The block SHALL have port clk, input, 1 bit: destination-domain clock; all flops are rising-edge.
REQ-004 The block SHALL have port resetb, input, 1 bit: synchronous, active-high reset; it is sampled on rising clk and is asserted when 1.
REQ-005 The block SHALL have port pulse_in, input, 1 bit: asynchronous level or pulse from the source domain.
REQ-006 The block SHALL have port pulse_out, output, 1 bit: synchronized result in the clk domain.
REQ-007 The block SHALL have port sync_level, output, 1 bit: the final synchronizer stage, sync[STAGES-1].

Function
REQ-008 The block SHALL implement a shift chain sync[0..STAGES-1]: sync[0] <= pulse_in, sync[i] <= sync[i-1] on every rising clk.
REQ-009 No logic SHALL sit between pulse_in and sync[0] or between chain stages.
REQ-010 pulse_in high sampled at edge N SHALL make sync_level 1 after edge N+STAGES-1 (latency: STAGES cycles).
REQ-011 When DFF_EDGE_DET_EN is defined: a flop sync_d SHALL register sync[STAGES-1].
REQ-012 When DFF_EDGE_DET_EN is defined: pulse_out SHALL equal sync[STAGES-1] & ~sync_d, high for exactly one clk cycle per rising edge of the synchronized level.
REQ-013 When DFF_EDGE_DET_EN is defined: a pulse_in held high for K cycles SHALL produce exactly one pulse_out cycle.
REQ-014 When DFF_EDGE_DET_EN is defined: a pulse_in high shorter than one clk period that no edge samples MAY be lost; no recovery is required.
REQ-015 Back-to-back input pulses separated by at least one low sample SHALL each produce a distinct output pulse.
REQ-016 pulse_out SHALL be glitch-free, derived only from flop outputs.

Reset
REQ-017 While resetb=1 at a rising clk, all sync flops and sync_d SHALL load RESET_VAL.
REQ-018 With RESET_VAL=0, pulse_out and sync_level SHALL be 0 in the cycle after a reset edge.
REQ-019 A reset asserted mid-propagation SHALL discard the in-flight pulse, with no output pulse afterwards.
REQ-020 After reset release with pulse_in held at 1, one output pulse SHALL appear STAGES cycles later.
REQ-021 The block SHALL have no asynchronous reset path.

Configuration
REQ-022 The macro DFF_EDGE_DET_EN SHALL select rising-edge detection.
REQ-023 With DFF_EDGE_DET_EN defined, pulse_out SHALL be the one-cycle edge pulse of REQ-012.
REQ-024 Without DFF_EDGE_DET_EN, sync_d SHALL be absent and pulse_out SHALL equal sync_level (pure level synchronizer, same latency).

Structure
REQ-025 Package dff_pkg SHALL hold the constants DFF_MIN_STAGES=2, DFF_MAX_STAGES=8 and DFF_DEFAULT_STAGES=2.
REQ-026 A STAGES value outside DFF_MIN_STAGES..DFF_MAX_STAGES SHALL fail elaboration.
REQ-027 The block SHALL contain one sub-module, dff_sync_stage: a single resettable flop (clk, resetb, d, q, parameter RESET_VAL), instantiated STAGES times by generate.
REQ-028 Synchronizer flops SHALL carry the ASYNC_REG synthesis attribute.

Verification
REQ-029 The bench SHALL use a destination clk period of 10 ns and a source clock period of 20 ns.
REQ-030 Reset: resetb=1 for 2 edges with pulse_in=0 -> pulse_out=0 and sync_level=0 throughout and after release.
REQ-031 Single pulse: pulse_in=1 for 10 ns (one posedge to the following negedge of the source clock), STAGES=2, edge detection on -> exactly one pulse_out cycle, rising 2 cycles after the sampling edge.
REQ-032 Long level: pulse_in=1 for 50 ns -> one pulse_out cycle; sync_level high for 5 cycles, delayed by 2.
REQ-033 Mid-flight reset: pulse_in sampled high, resetb=1 on the next edge, pulse_in=0 -> no pulse_out.
REQ-034 STAGES=4 without DFF_EDGE_DET_EN: pulse_in=1 for 3 cycles -> pulse_out high for 3 cycles, starting 4 edges after the first sample.
REQ-035 Two pulses of 1 cycle separated by 2 low cycles -> two distinct one-cycle pulse_out assertions, 3 cycles apart.
